// File: rtl/vram_arbiter_if.sv
// Host port bundle for vram_arbiter.
// Handshake: the host raises host_req_i with host_we_i/host_addr_i/host_wdata_i
// stable and holds all four until host_ack_o pulses high for exactly one cycle.
// host_rdata_o is valid in the ack cycle for reads and keeps its previous value
// for writes. A request still high in the ack cycle is the one just completed;
// a new request is taken no earlier than the cycle after the ack.
interface vram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              host_req_i;
  logic              host_we_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic [DATA_W-1:0] host_wdata_i;
  logic              host_ack_o;
  logic [DATA_W-1:0] host_rdata_o;

  modport master (output host_req_i, host_we_i, host_addr_i, host_wdata_i,
                  input  host_ack_o, host_rdata_o);
  modport slave  (input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
                  output host_ack_o, host_rdata_o);
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port VRAM between the line fetch engine and one
// host port. Display owns one slot every FETCH_PERIOD cycles while fetching a
// line; the host gets every other cycle. Pipeline: decision at N, VRAM request
// registered at N+1, read data at N+2, line-buffer write / host ack at N+3.
// Optional feature macro: VRAM_ARB_LINE_DOUBLE_EN (each source line fetched twice).
module vram_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 160,
  parameter int LINE_STRIDE    = 160,
  parameter int FETCH_PERIOD   = 4
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              fetch_line_i,
  input  logic              fetch_en_i,
  input  logic              end_of_frame_i,
  input  logic [ADDR_W-1:0] disp_base_i,
  output logic              disp_wr_o,
  output logic [9:0]        disp_index_o,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              overrun_o,
  vram_arbiter_if.slave     host,
  output logic              vram_sel_o,
  output logic              vram_we_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [DATA_W-1:0] vram_wdata_o,
  input  logic [DATA_W-1:0] vram_rdata_i,
  output logic              dbg_fetch_state_o,
  output logic [1:0]        dbg_host_state_o
);

  localparam logic [0:0] F_IDLE  = 1'b0;
  localparam logic [0:0] F_FETCH = 1'b1;

  localparam logic [1:0] H_IDLE  = 2'd0;
  localparam logic [1:0] H_ISSUE = 2'd1;
  localparam logic [1:0] H_WAIT  = 2'd2;

  // Fetch engine state
  logic [0:0]        r_fstate;
  logic [9:0]        r_word_cnt;
  logic [2:0]        r_ph;
  logic [ADDR_W-1:0] r_line_addr;
  logic              r_overrun;

  // Host engine state
  logic [1:0]        r_hstate;
  logic              r_h_we;
  logic              r_host_ack;
  logic [DATA_W-1:0] r_host_rdata;

  // VRAM request registers
  logic              r_vram_sel;
  logic              r_vram_we;
  logic [ADDR_W-1:0] r_vram_addr;
  logic [DATA_W-1:0] r_vram_wdata;

  // Display return pipeline (tracks which cycles carry display read data)
  logic              r_dp1_vld, r_dp2_vld;
  logic [9:0]        r_dp1_idx, r_dp2_idx;
  logic              r_disp_wr;
  logic [9:0]        r_disp_idx;
  logic [DATA_W-1:0] r_disp_data;

  logic w_start, w_slot, w_last, w_line_done, w_adv, w_host_acc;

  // A strobe while fetching restarts the line; the slot that would coincide
  // with the restart is dropped so word 0 of the new line comes next cycle.
  assign w_start     = fetch_line_i & fetch_en_i;
  assign w_slot      = (r_fstate == F_FETCH) && (r_ph == 3'd0) && !w_start;
  assign w_last      = w_slot && (r_word_cnt == 10'(WORDS_PER_LINE - 1));
  assign w_line_done = w_last || (w_start && (r_fstate == F_FETCH));
  // Host is only accepted off display slots and never in its own ack cycle.
  assign w_host_acc  = (r_hstate == H_IDLE) && host.host_req_i && !w_slot && !r_host_ack;

`ifdef VRAM_ARB_LINE_DOUBLE_EN
  logic r_parity;
  assign w_adv = w_line_done && r_parity;

  // Line parity: toggles per finished (or restarted) line, cleared at frame start
  always_ff @(posedge clk) begin
    if (reset_i || end_of_frame_i) r_parity <= 1'b0;
    else if (w_line_done)          r_parity <= ~r_parity;
  end
`else
  assign w_adv = w_line_done;
`endif

  // Fetch FSM: slot phase, word counter and sticky overrun flag
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_fstate   <= F_IDLE;
      r_word_cnt <= '0;
      r_ph       <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_start) begin
        r_fstate   <= F_FETCH;
        r_word_cnt <= '0;
        r_ph       <= '0;
        if (r_fstate == F_FETCH) r_overrun <= 1'b1;
      end else if (r_fstate == F_FETCH) begin
        r_ph <= (r_ph == 3'(FETCH_PERIOD - 1)) ? 3'd0 : r_ph + 3'd1;
        if (w_slot) begin
          r_word_cnt <= r_word_cnt + 10'd1;
          if (w_last) r_fstate <= F_IDLE;
        end
      end
    end
  end

  // Line address: frame reload wins over any pending stride advance
  always_ff @(posedge clk) begin
    if (reset_i)             r_line_addr <= '0;
    else if (end_of_frame_i) r_line_addr <= disp_base_i;
    else if (w_adv)          r_line_addr <= r_line_addr + ADDR_W'(LINE_STRIDE);
  end

  // VRAM request: exactly one owner per cycle, display first
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_vram_sel   <= 1'b0;
      r_vram_we    <= 1'b0;
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
    end else begin
      r_vram_sel <= 1'b0;
      r_vram_we  <= 1'b0;
      if (w_slot) begin
        r_vram_sel  <= 1'b1;
        r_vram_addr <= r_line_addr + ADDR_W'(r_word_cnt);
      end else if (w_host_acc) begin
        r_vram_sel   <= 1'b1;
        r_vram_we    <= host.host_we_i;
        r_vram_addr  <= host.host_addr_i;
        r_vram_wdata <= host.host_wdata_i;
      end
    end
  end

  // Display return path: carry word index alongside the read, write line buffer
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_dp1_vld   <= 1'b0;
      r_dp1_idx   <= '0;
      r_dp2_vld   <= 1'b0;
      r_dp2_idx   <= '0;
      r_disp_wr   <= 1'b0;
      r_disp_idx  <= '0;
      r_disp_data <= '0;
    end else begin
      r_dp1_vld <= w_slot;
      r_dp1_idx <= r_word_cnt;
      r_dp2_vld <= r_dp1_vld;
      r_dp2_idx <= r_dp1_idx;
      r_disp_wr <= r_dp2_vld;
      if (r_dp2_vld) begin
        r_disp_idx  <= r_dp2_idx;
        r_disp_data <= vram_rdata_i;
      end
    end
  end

  // Host FSM: accept, issue, then capture data and pulse ack
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_hstate     <= H_IDLE;
      r_h_we       <= 1'b0;
      r_host_ack   <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_host_ack <= 1'b0;
      case (r_hstate)
        H_IDLE: begin
          if (w_host_acc) begin
            r_h_we   <= host.host_we_i;
            r_hstate <= H_ISSUE;
          end
        end
        H_ISSUE: r_hstate <= H_WAIT;
        H_WAIT: begin
          r_host_ack <= 1'b1;
          if (!r_h_we) r_host_rdata <= vram_rdata_i;
          r_hstate <= H_IDLE;
        end
        default: r_hstate <= H_IDLE;
      endcase
    end
  end

  assign disp_wr_o         = r_disp_wr;
  assign disp_index_o      = r_disp_idx;
  assign disp_data_o       = r_disp_data;
  assign overrun_o         = r_overrun;
  assign host.host_ack_o   = r_host_ack;
  assign host.host_rdata_o = r_host_rdata;
  assign vram_sel_o        = r_vram_sel;
  assign vram_we_o         = r_vram_we;
  assign vram_addr_o       = r_vram_addr;
  assign vram_wdata_o      = r_vram_wdata;
  assign dbg_fetch_state_o = r_fstate;
  assign dbg_host_state_o  = r_hstate;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: line fetch timing/addresses, host write and
// read-back, display-vs-host slot conflict, overrun restart, frame reload,
// randomized host traffic during a fetch, and reset during a host access.
module tb_vram_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic              fetch_line_i, fetch_en_i, end_of_frame_i;
  logic [ADDR_W-1:0] disp_base_i;
  logic              disp_wr_o;
  logic [9:0]        disp_index_o;
  logic [DATA_W-1:0] disp_data_o;
  logic              overrun_o;
  logic              vram_sel_o, vram_we_o;
  logic [ADDR_W-1:0] vram_addr_o;
  logic [DATA_W-1:0] vram_wdata_o;
  logic [DATA_W-1:0] vram_rdata_i = '0;
  logic              dbg_fetch_state_o;
  logic [1:0]        dbg_host_state_o;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host_if ();

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(160),
    .LINE_STRIDE(160), .FETCH_PERIOD(4)
  ) dut (
    .clk(clk), .reset_i(reset_i),
    .fetch_line_i(fetch_line_i), .fetch_en_i(fetch_en_i),
    .end_of_frame_i(end_of_frame_i), .disp_base_i(disp_base_i),
    .disp_wr_o(disp_wr_o), .disp_index_o(disp_index_o), .disp_data_o(disp_data_o),
    .overrun_o(overrun_o), .host(host_if),
    .vram_sel_o(vram_sel_o), .vram_we_o(vram_we_o), .vram_addr_o(vram_addr_o),
    .vram_wdata_o(vram_wdata_o), .vram_rdata_i(vram_rdata_i),
    .dbg_fetch_state_o(dbg_fetch_state_o), .dbg_host_state_o(dbg_host_state_o)
  );

  // VRAM model: unwritten words read as addr ^ 16'h5A5A, data one cycle after select
  logic [DATA_W-1:0] vram_mem [int];
  always @(posedge clk) begin
    if (vram_sel_o) begin
      if (vram_we_o) vram_mem[int'(vram_addr_o)] = vram_wdata_o;
      else vram_rdata_i <= vram_mem.exists(int'(vram_addr_o)) ?
                           vram_mem[int'(vram_addr_o)] : (vram_addr_o ^ 16'h5A5A);
    end
  end

  // Expected memory contents, maintained from the stimulus side only
  logic [DATA_W-1:0] exp_mem [int];
  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
    return a ^ 16'h5A5A;
  endfunction

  // Scoreboard counters
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_line();
    fetch_line_i = 1'b1;
    tick();
    fetch_line_i = 1'b0;
  endtask

  // Full line check; call right after the strobe edge (tick 0)
  task automatic check_line(input logic [ADDR_W-1:0] base, input string tag);
    int n_wr;
    logic exp_sel, exp_wr;
    n_wr = 0;
    for (int t = 1; t <= 645; t++) begin
      tick();
      exp_sel = (t <= 637) && ((t - 1) % 4 == 0);
      exp_wr  = (t >= 3) && (t <= 639) && ((t - 3) % 4 == 0);
      chk({tag, "_sel"}, vram_sel_o, exp_sel);
      if (exp_sel) begin
        chk({tag, "_addr"}, vram_addr_o, base + 16'((t - 1) / 4));
        chk({tag, "_we"}, vram_we_o, 1'b0);
      end
      chk({tag, "_wr"}, disp_wr_o, exp_wr);
      if (exp_wr) begin
        chk({tag, "_idx"}, disp_index_o, 10'((t - 3) / 4));
        chk({tag, "_data"}, disp_data_o, exp_read(base + 16'((t - 3) / 4)));
      end
      if (disp_wr_o) n_wr++;
    end
    chk({tag, "_cnt"}, n_wr, 160);
    chk({tag, "_idle"}, dbg_fetch_state_o, 1'b0);
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

`ifdef VRAM_ARB_LINE_DOUBLE_EN
  localparam logic [15:0] L1_BASE  = 16'h1000;
  localparam logic [15:0] RST_BASE = 16'h10A0;
`else
  localparam logic [15:0] L1_BASE  = 16'h10A0;
  localparam logic [15:0] RST_BASE = 16'h1140;
`endif

  initial begin
    logic [DATA_W-1:0] last_rdata;
    logic              pend, h_we, exp_sel, host_sel, exp_wr;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    int                exp_ack, n_sel;

    reset_i = 1'b1; fetch_line_i = 1'b0; fetch_en_i = 1'b0; end_of_frame_i = 1'b0;
    disp_base_i = '0;
    host_if.host_req_i = 1'b0; host_if.host_we_i = 1'b0;
    host_if.host_addr_i = '0; host_if.host_wdata_i = '0;
    last_rdata = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_sel", vram_sel_o, 1'b0);
    chk("rst_we", vram_we_o, 1'b0);
    chk("rst_addr", vram_addr_o, 16'h0);
    chk("rst_wr", disp_wr_o, 1'b0);
    chk("rst_idx", disp_index_o, 10'h0);
    chk("rst_ovr", overrun_o, 1'b0);
    chk("rst_ack", host_if.host_ack_o, 1'b0);
    chk("rst_rdata", host_if.host_rdata_o, 16'h0);
    chk("rst_fsm", {dbg_host_state_o, dbg_fetch_state_o}, 3'b000);
    reset_i = 1'b0;

    // Frame base load, then a strobe with fetch disabled is ignored
    disp_base_i = 16'h1000; end_of_frame_i = 1'b1; tick(); end_of_frame_i = 1'b0;
    strobe_line();
    n_sel = 0;
    repeat (8) begin tick(); if (vram_sel_o) n_sel++; end
    chk("ign_sel", n_sel, 0);
    chk("ign_fsm", dbg_fetch_state_o, 1'b0);

    // Line 0 from 0x1000
    fetch_en_i = 1'b1;
    strobe_line();
    check_line(16'h1000, "l0");

    // Line 1, restarted after word 50
    strobe_line();
    tick();
    chk("l1_first", vram_addr_o, L1_BASE);
    chk("l1_first_sel", vram_sel_o, 1'b1);
    repeat (200) tick();
    chk("l1_w50_sel", vram_sel_o, 1'b1);
    chk("l1_w50_addr", vram_addr_o, L1_BASE + 16'd50);
    chk("ovr_pre", overrun_o, 1'b0);
    strobe_line();
    chk("ovr_set", overrun_o, 1'b1);
    tick();
    chk("ovr_sel", vram_sel_o, 1'b1);
    chk("ovr_addr", vram_addr_o, RST_BASE);
    chk("ovr_old_wr", disp_wr_o, 1'b1);
    chk("ovr_old_idx", disp_index_o, 10'd50);
    tick(); tick();
    chk("ovr_new_wr", disp_wr_o, 1'b1);
    chk("ovr_new_idx", disp_index_o, 10'd0);
    chk("ovr_new_data", disp_data_o, exp_read(RST_BASE));
    repeat (640) tick();
    chk("ovr_sticky", overrun_o, 1'b1);
    chk("ovr_idle", dbg_fetch_state_o, 1'b0);

    // Host write then read-back while display idle
    host_if.host_we_i = 1'b1; host_if.host_addr_i = 16'h0005;
    host_if.host_wdata_i = 16'hBEEF; host_if.host_req_i = 1'b1;
    tick();
    chk("hw_sel", vram_sel_o, 1'b1);
    chk("hw_we", vram_we_o, 1'b1);
    chk("hw_addr", vram_addr_o, 16'h0005);
    chk("hw_wdata", vram_wdata_o, 16'hBEEF);
    chk("hw_ack1", host_if.host_ack_o, 1'b0);
    tick();
    chk("hw_ack2", host_if.host_ack_o, 1'b0);
    tick();
    chk("hw_ack3", host_if.host_ack_o, 1'b1);
    chk("hw_rdata_hold", host_if.host_rdata_o, last_rdata);
    exp_mem[5] = 16'hBEEF;
    host_if.host_req_i = 1'b0;
    tick();
    chk("hw_ack_pulse", host_if.host_ack_o, 1'b0);
    host_if.host_we_i = 1'b0; host_if.host_req_i = 1'b1;
    tick();
    chk("hr_sel", vram_sel_o, 1'b1);
    chk("hr_we", vram_we_o, 1'b0);
    chk("hr_addr", vram_addr_o, 16'h0005);
    tick(); tick();
    chk("hr_ack", host_if.host_ack_o, 1'b1);
    chk("hr_rdata", host_if.host_rdata_o, 16'hBEEF);
    last_rdata = 16'hBEEF;
    host_if.host_req_i = 1'b0;

    // Host request landing on a display slot
    disp_base_i = 16'h3000; end_of_frame_i = 1'b1; tick(); end_of_frame_i = 1'b0;
    strobe_line();
    repeat (4) tick();
    host_if.host_we_i = 1'b0; host_if.host_addr_i = 16'h0100; host_if.host_req_i = 1'b1;
    tick();
    chk("cf_disp_addr", vram_addr_o, 16'h3001);
    chk("cf_disp_we", vram_we_o, 1'b0);
    tick();
    chk("cf_host_sel", vram_sel_o, 1'b1);
    chk("cf_host_addr", vram_addr_o, 16'h0100);
    tick();
    chk("cf_ack_early", host_if.host_ack_o, 1'b0);
    tick();
    chk("cf_ack", host_if.host_ack_o, 1'b1);
    chk("cf_rdata", host_if.host_rdata_o, exp_read(16'h0100));
    last_rdata = exp_read(16'h0100);
    host_if.host_req_i = 1'b0;
    repeat (640) tick();

    // Random host traffic during a fetch from 0x4000
    disp_base_i = 16'h4000; end_of_frame_i = 1'b1; tick(); end_of_frame_i = 1'b0;
    strobe_line();
    pend = 1'b0; exp_ack = 0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    for (int t = 1; t <= 660; t++) begin
      tick();
      exp_sel  = (t <= 637) && ((t - 1) % 4 == 0);
      host_sel = pend && (t == exp_ack - 2);
      chk("rnd_sel", vram_sel_o, exp_sel | host_sel);
      if (exp_sel) chk("rnd_daddr", vram_addr_o, 16'h4000 + 16'((t - 1) / 4));
      if (host_sel) begin
        chk("rnd_haddr", vram_addr_o, h_addr);
        chk("rnd_hwe", vram_we_o, h_we);
        if (h_we) chk("rnd_hwdata", vram_wdata_o, h_wdata);
      end
      exp_wr = (t >= 3) && (t <= 639) && ((t - 3) % 4 == 0);
      chk("rnd_wr", disp_wr_o, exp_wr);
      if (exp_wr) chk("rnd_ddata", disp_data_o, exp_read(16'h4000 + 16'((t - 3) / 4)));
      chk("rnd_ack", host_if.host_ack_o, pend && (t == exp_ack));
      if (pend && (t == exp_ack)) begin
        chk("rnd_rdata", host_if.host_rdata_o, h_we ? last_rdata : exp_read(h_addr));
        if (!h_we) last_rdata = exp_read(h_addr);
        pend = 1'b0;
        host_if.host_req_i = 1'b0;
      end else if (!pend && (t <= 650) && ($urandom_range(0, 1) == 1)) begin
        h_we    = 1'($urandom_range(0, 1));
        h_addr  = 16'($urandom_range(0, 255));
        h_wdata = 16'($urandom_range(0, 65535));
        host_if.host_we_i = h_we; host_if.host_addr_i = h_addr;
        host_if.host_wdata_i = h_wdata; host_if.host_req_i = 1'b1;
        pend    = 1'b1;
        exp_ack = t + (((t % 4 == 0) && (t <= 636)) ? 4 : 3);
        if (h_we) exp_mem[int'(h_addr)] = h_wdata;
      end
    end

    // Frame reload coinciding with the fetch strobe
    disp_base_i = 16'h2000; end_of_frame_i = 1'b1;
    strobe_line();
    end_of_frame_i = 1'b0;
    check_line(16'h2000, "eof0");
`ifdef VRAM_ARB_LINE_DOUBLE_EN
    strobe_line();
    check_line(16'h2000, "dbl1");
`endif
    strobe_line();
    check_line(16'h20A0, "eof1");

    // Reset while host access sits in the wait state
    host_if.host_we_i = 1'b0; host_if.host_addr_i = 16'h0005; host_if.host_req_i = 1'b1;
    tick();
    tick();
    chk("rw_state", dbg_host_state_o, 2'd2);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("rw_ack", host_if.host_ack_o, 1'b0);
    chk("rw_sel", vram_sel_o, 1'b0);
    chk("rw_addr", vram_addr_o, 16'h0);
    chk("rw_wdata", vram_wdata_o, 16'h0);
    chk("rw_rdata", host_if.host_rdata_o, 16'h0);
    chk("rw_ovr", overrun_o, 1'b0);
    chk("rw_wr", disp_wr_o, 1'b0);
    chk("rw_ddata", disp_data_o, 16'h0);
    tick();
    chk("rw2_sel", vram_sel_o, 1'b1);
    chk("rw2_addr", vram_addr_o, 16'h0005);
    tick();
    chk("rw2_ack_early", host_if.host_ack_o, 1'b0);
    tick();
    chk("rw2_ack", host_if.host_ack_o, 1'b1);
    chk("rw2_rdata", host_if.host_rdata_o, 16'hBEEF);
    host_if.host_req_i = 1'b0;
    tick();
    chk("rw2_ack_pulse", host_if.host_ack_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
